// File: rtl/uart_transmitter.sv
// UART transmit engine: serialises one byte into start, 5-8 data bits (LSB first),
// optional parity and 1 or 2 stop bits, paced by the shared single-cycle baud tick.
module uart_transmitter #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_en_i,
    input  logic                  tick_1x_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic [1:0]            data_bits_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  stop2_i,
    output logic                  tx_ready_o,
    output logic                  tx_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP,
        FINISH
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] data_masked;
    logic [3:0]            bit_cnt, bit_cnt_next;
    logic [3:0]            num_bits, num_bits_next;
    logic [3:0]            len_in;
    logic                  stop_cnt, stop_cnt_next;
    logic                  parity_bit, parity_next;
    logic                  parity_en, parity_en_next;
    logic                  stop2, stop2_next;
    logic                  tx_reg, tx_next;
    logic                  accept;

    assign len_in     = 4'd5 + {2'b00, data_bits_i};
    assign tx_ready_o = (state == IDLE) & tx_en_i;
    assign accept     = data_valid_i & tx_ready_o;
    assign tx_o       = tx_reg;
    assign tx_busy_o  = (state != IDLE);
    assign tx_done_o  = (state == FINISH);

    // Bits above the selected frame length must not influence parity.
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_masked[i] = data_i[i] & (i < int'(len_in));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            num_bits   <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            parity_en  <= 1'b0;
            stop2      <= 1'b0;
            tx_reg     <= IDLE_LEVEL;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            num_bits   <= num_bits_next;
            stop_cnt   <= stop_cnt_next;
            parity_bit <= parity_next;
            parity_en  <= parity_en_next;
            stop2      <= stop2_next;
            tx_reg     <= tx_next;
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt;
        num_bits_next  = num_bits;
        stop_cnt_next  = stop_cnt;
        parity_next    = parity_bit;
        parity_en_next = parity_en;
        stop2_next     = stop2;
        tx_next        = tx_reg;

        case (state)
            IDLE: begin
                tx_next = IDLE_LEVEL;
                if (accept) begin
                    shift_next     = data_i;
                    num_bits_next  = len_in;
                    parity_next    = (^data_masked) ^ parity_odd_i;
                    parity_en_next = parity_en_i;
                    stop2_next     = stop2_i;
                    bit_cnt_next   = '0;
                    stop_cnt_next  = 1'b0;
                    state_next     = SYNC;
                end
            end
            SYNC: begin
                if (tick_1x_i) begin
                    tx_next    = ~IDLE_LEVEL;
                    state_next = START;
                end
            end
            START: begin
                if (tick_1x_i) begin
                    tx_next      = shift_reg[0];
                    bit_cnt_next = 4'd1;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick_1x_i) begin
                    if (bit_cnt < num_bits) begin
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (parity_en) begin
                        tx_next    = parity_bit;
                        state_next = PARITY;
                    end else begin
                        tx_next    = IDLE_LEVEL;
                        state_next = STOP;
                    end
                end
            end
            PARITY: begin
                if (tick_1x_i) begin
                    tx_next    = IDLE_LEVEL;
                    state_next = STOP;
                end
            end
            STOP: begin
                // stop_cnt counts completed stop periods; stop2 is the last index needed.
                if (tick_1x_i) begin
                    if (stop_cnt == stop2) begin
                        state_next = FINISH;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-level scoreboard is filled when a
// byte is offered and drained by a line monitor that samples every bit period.
module tb_uart_transmitter;

    localparam int T = 16;

    logic       clk;
    logic       reset_n;
    logic       tx_en_i;
    logic       tick_1x_i;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic [1:0] data_bits_i;
    logic       parity_en_i;
    logic       parity_odd_i;
    logic       stop2_i;
    logic       tx_ready_o;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    frame_t sb[$];
    int     n_compared = 0;
    int     n_mismatch = 0;
    int     done_count = 0;
    int     cycle = 0;
    int     last_done_cycle = -10;
    int     accept_cycle = 0;
    int     tick_cnt = 0;
    bit     mon_en = 1'b1;

    uart_transmitter #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_en_i      (tx_en_i),
        .tick_1x_i    (tick_1x_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_bits_i  (data_bits_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_ready_o   (tx_ready_o),
        .tx_o         (tx_o),
        .tx_busy_o    (tx_busy_o),
        .tx_done_o    (tx_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick_1x_i = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt  = (tick_cnt == T - 1) ? 0 : tick_cnt + 1;
            tick_1x_i = (tick_cnt == T - 1);
        end
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        forever begin
            @(negedge clk);
            if (tx_done_o === 1'b1) begin
                done_count++;
                last_done_cycle = cycle;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    function automatic frame_t build_frame(input logic [7:0] d, input logic [1:0] db,
                                           input logic pen, input logic odd, input logic s2);
        frame_t f;
        int     n;
        logic   p;
        n      = 5 + int'(db);
        p      = odd;
        f.bits = '0;
        f.len  = 1;
        for (int i = 0; i < n; i++) begin
            f.bits[f.len] = d[i];
            p             = p ^ d[i];
            f.len++;
        end
        if (pen) begin
            f.bits[f.len] = p;
            f.len++;
        end
        f.bits[f.len] = 1'b1;
        f.len++;
        if (s2) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    // Line monitor: a falling edge while idle opens a frame, then every negedge of each bit period is checked.
    initial begin
        frame_t f;
        logic   prev;
        logic   mid;
        bit     ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev === 1'b1 && tx_o === 1'b0) begin
                checkOutput("frame_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    f = sb.pop_front();
                    for (int b = 0; b < f.len; b++) begin
                        ok  = 1'b1;
                        mid = 1'bx;
                        for (int k = 0; k < T; k++) begin
                            if (!(b == 0 && k == 0)) @(negedge clk);
                            if (tx_o !== f.bits[b] || tx_busy_o !== 1'b1) ok = 1'b0;
                            if (k == T / 2) mid = tx_o;
                        end
                        checkOutput($sformatf("bit%0d", b), {31'd0, mid}, {31'd0, f.bits[b]});
                        checkOutput($sformatf("hold%0d", b), {31'd0, ok}, 1);
                    end
                    @(negedge clk);
                    checkOutput("done_pulse", {31'd0, tx_done_o}, 1);
                    checkOutput("ready_in_finish", {31'd0, tx_ready_o}, 0);
                    @(negedge clk);
                    checkOutput("done_low", {31'd0, tx_done_o}, 0);
                end
            end
            prev = tx_o;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] db, input logic pen,
                                 input logic odd, input logic s2, input bit hold_valid);
        int guard;
        data_i       = d;
        data_bits_i  = db;
        parity_en_i  = pen;
        parity_odd_i = odd;
        stop2_i      = s2;
        data_valid_i = 1'b1;
        guard        = 0;
        while (tx_ready_o !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_timeout", (guard < 500) ? 1 : 0, 1);
        accept_cycle = cycle;
        sb.push_back(build_frame(d, db, pen, odd, s2));
        @(negedge clk);
        if (!hold_valid) data_valid_i = 1'b0;
        checkOutput("busy_after_accept", {31'd0, tx_busy_o}, 1);
    endtask

    task automatic wait_done(input int n);
        int guard;
        guard = 0;
        while (done_count < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_timeout", (done_count >= n) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int saved;
        reset_n      = 1'b0;
        tx_en_i      = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 8'h00;
        data_bits_i  = 2'b11;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        stop2_i      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_tx", {31'd0, tx_o}, 1);
        checkOutput("rst_ready", {31'd0, tx_ready_o}, 0);
        checkOutput("rst_busy", {31'd0, tx_busy_o}, 0);
        checkOutput("rst_done", {31'd0, tx_done_o}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        tx_en_i = 1'b1;
        #1;
        checkOutput("ready_follows_en", {31'd0, tx_ready_o}, 1);

        applyStimulus(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(1);

        applyStimulus(8'h35, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(2);
        applyStimulus(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(3);

        applyStimulus(8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done(4);

        applyStimulus(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h80, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b_accept_cycle", accept_cycle, last_done_cycle + 1);
        wait_done(6);

        // Config and enable change mid-frame; the latched 8E2 frame must still complete.
        applyStimulus(8'h5A, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        data_bits_i  = 2'b00;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b1;
        stop2_i      = 1'b0;
        tx_en_i      = 1'b0;
        data_i       = 8'h00;
        data_valid_i = 1'b1;
        #1;
        checkOutput("ready_while_disabled", {31'd0, tx_ready_o}, 0);
        wait_done(7);
        repeat (3 * T) @(negedge clk);
        checkOutput("no_accept_disabled", {31'd0, tx_busy_o}, 0);
        checkOutput("ready_disabled_idle", {31'd0, tx_ready_o}, 0);
        data_valid_i = 1'b0;
        tx_en_i      = 1'b1;
        @(negedge clk);

        mon_en = 1'b0;
        applyStimulus(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        sb.delete();
        repeat (40) @(negedge clk);
        checkOutput("pre_reset_data_low", {31'd0, tx_o}, 0);
        saved = done_count;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_tx_async", {31'd0, tx_o}, 1);
        checkOutput("reset_busy", {31'd0, tx_busy_o}, 0);
        checkOutput("reset_done", {31'd0, tx_done_o}, 0);
        repeat (3) @(negedge clk);
        checkOutput("no_done_on_abort", done_count, saved);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        applyStimulus(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(saved + 1);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
